// File: rtl/vred_tree_acc.sv
// ---------------------------------------------------------------------------
// vred_tree_acc
//   Fully pipelined vector integer reduction unit (sum, minu, min, maxu, max,
//   and, or, xor). Each accepted beat is masked, collapsed to one SEW-wide
//   partial result by a registered halving tree, and folded into a
//   per-reduction accumulator that is seeded from in_vec1_i on the start beat.
//   One beat per cycle, no backpressure.
//
// Ports
//   clk_i        clock, all state on the rising edge
//   rst_i        synchronous active-high reset
//   in_vec0_i    beat data, packed SEW-wide elements
//   in_vec1_i    seed scalar (low SEW bits), used on the start beat only
//   in_mask_i    per-element enable; bits beyond the element count ignored
//   in_valid_i   beat qualifier
//   in_start_i   first beat of a reduction
//   in_end_i     last beat of a reduction
//   in_opSel_i   0 sum, 1 minu, 2 min, 3 maxu, 4 max, 5 and, 6 or, 7 xor
//   in_sew_i     element width code: 0=8b, 1=16b, 2=32b, 3=64b
//   in_addr_i    destination address, taken from the end beat
//   out_vec_o    zero-extended result, zero when out_valid_o is low
//   out_addr_o   address of the completing reduction, zero when idle
//   out_valid_o  one-cycle pulse per completed reduction
// ---------------------------------------------------------------------------
module vred_tree_acc #(
   parameter int DATA_WIDTH  = 64,
   parameter int ADDR_WIDTH  = 32,
   parameter int OPSEL_WIDTH = 3,
   parameter int SEW_WIDTH   = 2,
   parameter int MASK_WIDTH  = DATA_WIDTH / 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [DATA_WIDTH-1:0]  in_vec0_i,
   input  logic [DATA_WIDTH-1:0]  in_vec1_i,
   input  logic [MASK_WIDTH-1:0]  in_mask_i,
   input  logic                   in_valid_i,
   input  logic                   in_start_i,
   input  logic                   in_end_i,
   input  logic [OPSEL_WIDTH-1:0] in_opSel_i,
   input  logic [SEW_WIDTH-1:0]   in_sew_i,
   input  logic [ADDR_WIDTH-1:0]  in_addr_i,
   output logic [DATA_WIDTH-1:0]  out_vec_o,
   output logic [ADDR_WIDTH-1:0]  out_addr_o,
   output logic                   out_valid_o
);

   localparam int LVLS = $clog2(DATA_WIDTH / 8);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

   // ---------------------------------------------------------------- helpers
   function automatic int sew_bits(input logic [SEW_WIDTH-1:0] sew);
      int r;
      case (sew)
         2'd0:    r = 8;
         2'd1:    r = 16;
         2'd2:    r = 32;
         2'd3:    r = 64;
         default: r = 64;
      endcase
      return r;
   endfunction

   function automatic logic [63:0] sew_trunc(input logic [63:0] x, input logic [SEW_WIDTH-1:0] sew);
      logic [63:0] r;
      case (sew)
         2'd0:    r = {56'd0, x[7:0]};
         2'd1:    r = {48'd0, x[15:0]};
         2'd2:    r = {32'd0, x[31:0]};
         2'd3:    r = x;
         default: r = x;
      endcase
      return r;
   endfunction

   function automatic logic [63:0] sew_sext(input logic [63:0] x, input logic [SEW_WIDTH-1:0] sew);
      logic [63:0] r;
      case (sew)
         2'd0:    r = {{56{x[7]}}, x[7:0]};
         2'd1:    r = {{48{x[15]}}, x[15:0]};
         2'd2:    r = {{32{x[31]}}, x[31:0]};
         2'd3:    r = x;
         default: r = x;
      endcase
      return r;
   endfunction

   // Identity element of each op, low SEW bits meaningful.
   function automatic logic [63:0] elem_ident(input logic [OPSEL_WIDTH-1:0] op, input logic [SEW_WIDTH-1:0] sew);
      logic [63:0] r;
      case (op)
         3'd1, 3'd5: r = {64{1'b1}};
         3'd2: begin
            case (sew)
               2'd0:    r = 64'h0000_0000_0000_007F;
               2'd1:    r = 64'h0000_0000_0000_7FFF;
               2'd2:    r = 64'h0000_0000_7FFF_FFFF;
               default: r = 64'h7FFF_FFFF_FFFF_FFFF;
            endcase
         end
         3'd4: begin
            case (sew)
               2'd0:    r = 64'h0000_0000_0000_0080;
               2'd1:    r = 64'h0000_0000_0000_8000;
               2'd2:    r = 64'h0000_0000_8000_0000;
               default: r = 64'h8000_0000_0000_0000;
            endcase
         end
         default: r = 64'd0;
      endcase
      return r;
   endfunction

   // One SEW-wide operation; result truncated to SEW bits.
   function automatic logic [63:0] elem_op(input logic [OPSEL_WIDTH-1:0] op, input logic [SEW_WIDTH-1:0] sew,
                                           input logic [63:0] a, input logic [63:0] b);
      logic [63:0] a_t, b_t, a_s, b_s, r;
      a_t = sew_trunc(a, sew);
      b_t = sew_trunc(b, sew);
      a_s = sew_sext(a, sew);
      b_s = sew_sext(b, sew);
      case (op)
         3'd0:    r = a_t + b_t;
         3'd1:    r = (a_t < b_t) ? a_t : b_t;
         3'd2:    r = ($signed(a_s) < $signed(b_s)) ? a_t : b_t;
         3'd3:    r = (a_t > b_t) ? a_t : b_t;
         3'd4:    r = ($signed(a_s) > $signed(b_s)) ? a_t : b_t;
         3'd5:    r = a_t & b_t;
         3'd6:    r = a_t | b_t;
         3'd7:    r = a_t ^ b_t;
         default: r = 64'd0;
      endcase
      return sew_trunc(r, sew);
   endfunction

   // Element-wise op over whole vectors; zero elements combine to zero for every op.
   function automatic logic [DATA_WIDTH-1:0] vec_combine(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b,
                                                         input logic [OPSEL_WIDTH-1:0] op, input logic [SEW_WIDTH-1:0] sew);
      logic [DATA_WIDTH-1:0] r;
      logic [63:0]           t;
      r = '0;
      case (sew)
         2'd0: for (int e = 0; e < DATA_WIDTH / 8; e++) begin
            t = elem_op(op, sew, {56'd0, a[e*8 +: 8]}, {56'd0, b[e*8 +: 8]});
            r[e*8 +: 8] = t[7:0];
         end
         2'd1: for (int e = 0; e < DATA_WIDTH / 16; e++) begin
            t = elem_op(op, sew, {48'd0, a[e*16 +: 16]}, {48'd0, b[e*16 +: 16]});
            r[e*16 +: 16] = t[15:0];
         end
         2'd2: for (int e = 0; e < DATA_WIDTH / 32; e++) begin
            t = elem_op(op, sew, {32'd0, a[e*32 +: 32]}, {32'd0, b[e*32 +: 32]});
            r[e*32 +: 32] = t[31:0];
         end
         2'd3: for (int e = 0; e < DATA_WIDTH / 64; e++) begin
            r[e*64 +: 64] = elem_op(op, sew, a[e*64 +: 64], b[e*64 +: 64]);
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   // Replace inactive elements by the op identity.
   function automatic logic [DATA_WIDTH-1:0] mask_fill(input logic [DATA_WIDTH-1:0] v, input logic [MASK_WIDTH-1:0] m,
                                                       input logic [OPSEL_WIDTH-1:0] op, input logic [SEW_WIDTH-1:0] sew);
      logic [DATA_WIDTH-1:0] r;
      logic [63:0]           id;
      id = elem_ident(op, sew);
      r  = '0;
      case (sew)
         2'd0: for (int e = 0; e < DATA_WIDTH / 8; e++)  r[e*8 +: 8]   = m[e] ? v[e*8 +: 8]   : id[7:0];
         2'd1: for (int e = 0; e < DATA_WIDTH / 16; e++) r[e*16 +: 16] = m[e] ? v[e*16 +: 16] : id[15:0];
         2'd2: for (int e = 0; e < DATA_WIDTH / 32; e++) r[e*32 +: 32] = m[e] ? v[e*32 +: 32] : id[31:0];
         2'd3: for (int e = 0; e < DATA_WIDTH / 64; e++) r[e*64 +: 64] = m[e] ? v[e*64 +: 64] : id;
         default: r = '0;
      endcase
      return r;
   endfunction

   // One halving level: fold upper half onto lower half. Once the half is
   // narrower than SEW the element already sits in the low SEW bits, so the
   // value passes through untouched.
   function automatic logic [DATA_WIDTH-1:0] tree_level(input logic [DATA_WIDTH-1:0] prev, input int hw,
                                                        input logic [OPSEL_WIDTH-1:0] op, input logic [SEW_WIDTH-1:0] sew);
      logic [DATA_WIDTH-1:0] lo, hi, r;
      lo = prev & ~({DATA_WIDTH{1'b1}} << hw);
      hi = (prev >> hw) & ~({DATA_WIDTH{1'b1}} << hw);
      if (sew_bits(sew) <= hw) begin
         r = vec_combine(lo, hi, op, sew);
      end else begin
         r = prev;
      end
      return r;
   endfunction

   // ------------------------------------------------------------ control FSM
   state_t                 state_q, state_d;
   logic [OPSEL_WIDTH-1:0] cfg_op_q;
   logic [SEW_WIDTH-1:0]   cfg_sew_q;
   logic                   beat_ok_s;
   logic [OPSEL_WIDTH-1:0] eff_op_s;
   logic [SEW_WIDTH-1:0]   eff_sew_s;

   // State register plus op/sew latched on an accepted start beat.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         cfg_op_q  <= '0;
         cfg_sew_q <= '0;
      end else begin
         state_q <= state_d;
         if (in_valid_i && in_start_i) begin
            cfg_op_q  <= in_opSel_i;
            cfg_sew_q <= in_sew_i;
         end
      end
   end

   // Next-state: a start always (re)opens a reduction, an end closes it.
   always_comb begin
      state_d = state_q;
      if (in_valid_i && in_start_i) begin
         if (in_end_i) begin
            state_d = ST_IDLE;
         end else begin
            state_d = ST_ACTIVE;
         end
      end else if (in_valid_i && in_end_i) begin
         state_d = ST_IDLE;
      end else begin
         state_d = state_q;
      end
   end

   // Beat acceptance and effective op/sew for the beat entering the pipe.
   always_comb begin
      beat_ok_s = 1'b0;
      case (state_q)
         ST_IDLE:   beat_ok_s = in_valid_i & in_start_i;
         ST_ACTIVE: beat_ok_s = in_valid_i;
         default:   beat_ok_s = 1'b0;
      endcase
      if (in_start_i) begin
         eff_op_s  = in_opSel_i;
         eff_sew_s = in_sew_i;
      end else begin
         eff_op_s  = cfg_op_q;
         eff_sew_s = cfg_sew_q;
      end
   end

   // ------------------------------------------------- mask stage + tree pipe
   logic [DATA_WIDTH-1:0]  dat_q  [0:LVLS];
   logic [DATA_WIDTH-1:0]  dat_d  [0:LVLS];
   logic [OPSEL_WIDTH-1:0] op_q   [0:LVLS];
   logic [OPSEL_WIDTH-1:0] op_d   [0:LVLS];
   logic [SEW_WIDTH-1:0]   sew_q  [0:LVLS];
   logic [SEW_WIDTH-1:0]   sew_d  [0:LVLS];
   logic [ADDR_WIDTH-1:0]  adr_q  [0:LVLS];
   logic [ADDR_WIDTH-1:0]  adr_d  [0:LVLS];
   logic [63:0]            seed_q [0:LVLS];
   logic [63:0]            seed_d [0:LVLS];
   logic [LVLS:0]          vld_q, vld_d, sta_q, sta_d, fin_q, fin_d;

   // Next values of every pipe stage: stage 0 from the inputs, the rest from the tree.
   always_comb begin
      dat_d[0]  = mask_fill(in_vec0_i, in_mask_i, eff_op_s, eff_sew_s);
      op_d[0]   = eff_op_s;
      sew_d[0]  = eff_sew_s;
      adr_d[0]  = in_addr_i;
      seed_d[0] = sew_trunc(in_vec1_i[63:0], eff_sew_s);
      vld_d     = '0;
      sta_d     = '0;
      fin_d     = '0;
      vld_d[0]  = beat_ok_s;
      sta_d[0]  = in_start_i;
      fin_d[0]  = in_end_i;
      for (int i = 1; i <= LVLS; i++) begin
         dat_d[i]  = tree_level(dat_q[i-1], DATA_WIDTH >> i, op_q[i-1], sew_q[i-1]);
         op_d[i]   = op_q[i-1];
         sew_d[i]  = sew_q[i-1];
         adr_d[i]  = adr_q[i-1];
         seed_d[i] = seed_q[i-1];
         vld_d[i]  = vld_q[i-1];
         sta_d[i]  = sta_q[i-1];
         fin_d[i]  = fin_q[i-1];
      end
   end

   // Pipe stage registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i <= LVLS; i++) begin
            dat_q[i]  <= '0;
            op_q[i]   <= '0;
            sew_q[i]  <= '0;
            adr_q[i]  <= '0;
            seed_q[i] <= 64'd0;
         end
         vld_q <= '0;
         sta_q <= '0;
         fin_q <= '0;
      end else begin
         for (int i = 0; i <= LVLS; i++) begin
            dat_q[i]  <= dat_d[i];
            op_q[i]   <= op_d[i];
            sew_q[i]  <= sew_d[i];
            adr_q[i]  <= adr_d[i];
            seed_q[i] <= seed_d[i];
         end
         vld_q <= vld_d;
         sta_q <= sta_d;
         fin_q <= fin_d;
      end
   end

   // ------------------------------------------------ accumulate and output
   logic [63:0]           acc_q, acc_d, partial_s, base_s;
   logic                  done_q, done_d;
   logic [ADDR_WIDTH-1:0] done_addr_q, done_addr_d;
   logic [DATA_WIDTH-1:0] out_vec_q, out_vec_d;
   logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
   logic                  out_valid_q;

   // Fold the tree result into the accumulator; a start beat reseeds it.
   always_comb begin
      partial_s = sew_trunc(dat_q[LVLS][63:0], sew_q[LVLS]);
      if (sta_q[LVLS]) begin
         base_s = seed_q[LVLS];
      end else begin
         base_s = acc_q;
      end
      if (vld_q[LVLS]) begin
         acc_d = elem_op(op_q[LVLS], sew_q[LVLS], base_s, partial_s);
      end else begin
         acc_d = acc_q;
      end
      done_d = vld_q[LVLS] & fin_q[LVLS];
      if (done_d) begin
         done_addr_d = adr_q[LVLS];
      end else begin
         done_addr_d = '0;
      end
   end

   // Output values: zero unless a reduction completes this cycle.
   always_comb begin
      out_vec_d = '0;
      if (done_q) begin
         out_vec_d[63:0] = acc_q;
         out_addr_d      = done_addr_q;
      end else begin
         out_addr_d      = '0;
      end
   end

   // Accumulator and output registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_q       <= 64'd0;
         done_q      <= 1'b0;
         done_addr_q <= '0;
         out_vec_q   <= '0;
         out_addr_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         done_q      <= done_d;
         done_addr_q <= done_addr_d;
         out_vec_q   <= out_vec_d;
         out_addr_q  <= out_addr_d;
         out_valid_q <= done_q;
      end
   end

   assign out_vec_o   = out_vec_q;
   assign out_addr_o  = out_addr_q;
   assign out_valid_o = out_valid_q;

endmodule
